// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared FSM states and framing constants for the program loader
package prog_loader_pkg;
    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CHK, DONE, ERR} state_t;
    localparam int HDR_BYTES = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/prog_loader_word_assembler.sv
// prog_loader_word_assembler: packs big-endian bytes into 32-bit words
module prog_loader_word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_full
);
    localparam int IW = $clog2(BYTES_PER_WORD);
    logic [IW-1:0]                 r_idx;
    logic [8*BYTES_PER_WORD-9:0]   r_sh;
    // shift earlier bytes toward the MSB; partial words survive input gaps
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_idx <= '0;
            r_sh  <= '0;
        end else if (i_en) begin
            r_idx <= r_idx + 1'b1;
            r_sh  <= {r_sh[8*BYTES_PER_WORD-17:0], i_byte};
        end
    end
    assign o_word = {r_sh, i_byte};
    assign o_full = i_en && (r_idx == IW'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a checksummed byte-framed image into instruction memory
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           word_count
);
    state_t      r_state, w_next;
    logic        w_acc, w_full, w_ready, w_done, w_err;
    logic [7:0]  r_cnt_hi, r_xacc;
    logic [15:0] r_widx, w_cnt;
    logic [31:0] w_word;

    assign w_acc = in_valid && in_ready;
    assign w_cnt = {r_cnt_hi, in_data};

    prog_loader_word_assembler u_asm (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_acc && r_state == HDR_LO),
        .i_en   (w_acc && r_state == DATA),
        .i_byte (in_data),
        .o_word (w_word),
        .o_full (w_full)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= HDR_HI;
        else     r_state <= w_next;
    end

    // next state: every transition is driven by an accepted byte
    always_comb begin
        w_next = r_state;
        case (r_state)
            HDR_HI:  w_next = w_acc ? HDR_LO : HDR_HI;
            HDR_LO:  w_next = !w_acc ? HDR_LO : int'(w_cnt) > MAX_WORDS ? ERR : w_cnt == 16'd0 ? CHK : DATA;
            DATA:    w_next = (w_full && r_widx == word_count - 16'd1) ? CHK : DATA;
            CHK:     w_next = !w_acc ? CHK : (in_data == r_xacc) ? DONE : ERR;
            default: w_next = r_state;
        endcase
    end

    // output decode from the next state so registered outputs line up with it
    always_comb begin
        w_ready = (w_next == HDR_HI) || (w_next == HDR_LO) || (w_next == DATA) || (w_next == CHK);
        w_done  = (w_next == DONE);
        w_err   = (w_next == ERR);
    end

    // registered outputs, header capture, checksum and write address tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            r_cnt_hi   <= '0;
            r_xacc     <= '0;
            r_widx     <= '0;
        end else begin
            in_ready <= w_ready;
            done     <= w_done;
            error    <= w_err;
            cpu_rst  <= !w_done;
            imem_we  <= w_full;
            if (w_full) begin
                imem_addr  <= r_widx[ADDR_WIDTH-1:0];
                imem_wdata <= w_word;
                r_widx     <= r_widx + 16'd1;
            end
            if (w_acc && r_state == HDR_HI) r_cnt_hi <= in_data;
            if (w_acc && r_state == HDR_LO) begin
                word_count <= w_cnt;
                r_widx     <= '0;
            end
            if (w_acc && r_state != CHK) r_xacc <= r_xacc ^ in_data;
        end
    end
endmodule
